// File: rtl/data_mem_v2_if.sv
// Request/response bus for data_mem_v2: a valid/ready request channel
// (read or write) and a one-cycle read response, plus the clear-sweep flag.
interface data_mem_v2_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] data_out;
    logic              init_busy;

    modport master (
        output req_valid, req_write, addr_in, data_in,
        input  req_ready, rsp_valid, data_out, init_busy
    );

    modport slave (
        input  req_valid, req_write, addr_in, data_in,
        output req_ready, rsp_valid, data_out, init_busy
    );
endinterface

// File: rtl/data_mem_v2.sv
// Single-port word memory with a valid/ready request port and 1-cycle read
// latency. FSM: IDLE -> (CLEAR) -> READY. When DATA_MEM_V2_INIT_CLEAR_EN is
// defined, every reset is followed by a DEPTH-cycle sweep that zeroes the
// array; otherwise the array keeps its contents across reset and the block
// goes straight to READY.
module data_mem_v2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input logic         CLK,
    input logic         RST_N,
    data_mem_v2_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic wr_en;
    logic clear_we;

    // req_ready is registered and only high in READY, so it alone qualifies a request.
    assign accept = bus.req_valid & bus.req_ready;
    assign wr_en  = accept & bus.req_write;
`ifdef DATA_MEM_V2_INIT_CLEAR_EN
    assign clear_we = (state == CLEAR);
`else
    assign clear_we = 1'b0;
`endif

    // Control FSM with registered outputs; reset does not touch the array.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            count         <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.init_busy <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef DATA_MEM_V2_INIT_CLEAR_EN
                    state         <= CLEAR;
                    count         <= '0;
                    bus.init_busy <= 1'b1;
`else
                    state         <= READY;
                    bus.req_ready <= 1'b1;
`endif
                end
                CLEAR: begin
                    count <= count + 1'b1;
                    if (&count) begin
                        state         <= READY;
                        bus.init_busy <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (accept && !bus.req_write) begin
                        bus.rsp_valid <= 1'b1;
                        bus.data_out  <= mem[bus.addr_in];
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b0;
                    bus.init_busy <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: the clear sweep has priority, requests cannot occur then anyway.
    always_ff @(posedge CLK) begin
        if (clear_we) begin
            mem[count] <= '0;
        end else if (wr_en) begin
            mem[bus.addr_in] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_data_mem_v2.sv
// Bench for data_mem_v2: a default-size instance checked against an
// array model under directed and random traffic, plus a 16x16 instance
// for the small-geometry sweep. Works with DATA_MEM_V2_INIT_CLEAR_EN
// defined or undefined.
module tb_data_mem_v2;
    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int DEPTH  = 256;
    localparam int SDW    = 16;
    localparam int SAW    = 4;
    localparam int SDEPTH = 16;

`ifdef DATA_MEM_V2_INIT_CLEAR_EN
    localparam int EXP_BUSY   = DEPTH;
    localparam int EXP_SBUSY  = SDEPTH;
`else
    localparam int EXP_BUSY   = 0;
    localparam int EXP_SBUSY  = 0;
`endif
    localparam int EXP_CYCLES = EXP_BUSY + 1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    data_mem_v2_if #(.DATA_W(DW),  .ADDR_W(AW))  bus ();
    data_mem_v2_if #(.DATA_W(SDW), .ADDR_W(SAW)) sbus ();

    data_mem_v2 #(.DATA_W(DW),  .ADDR_W(AW))  dut   (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    data_mem_v2 #(.DATA_W(SDW), .ADDR_W(SAW)) dut_s (.CLK(CLK), .RST_N(RST_N), .bus(sbus));

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_dout;

    task automatic drive(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.addr_in   = a;
        bus.data_in   = d;
    endtask

    task automatic sdrive(input bit v, input bit w, input logic [SAW-1:0] a, input logic [SDW-1:0] d);
        sbus.req_valid = v;
        sbus.req_write = w;
        sbus.addr_in   = a;
        sbus.data_in   = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory model for a request accepted in READY: writes land, reads return current word.
    task automatic model_step(input bit v, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output bit exp_rsp);
        exp_rsp = 1'b0;
        if (v) begin
            if (w) begin
                model[a] = d;
            end else begin
                exp_rsp  = 1'b1;
                exp_dout = model[a];
            end
        end
    endtask

    // What reset does to the observable memory: zeroed by the sweep, else untouched.
    task automatic model_reset();
        exp_dout = '0;
`ifdef DATA_MEM_V2_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    endtask

    // Release reset (inputs as currently driven for the first edge), then wait for ready.
    task automatic release_and_count(output int cycles, output int busy, output int sbusy);
        cycles = 0;
        busy   = 0;
        sbusy  = 0;
        RST_N  = 1'b1;
        while (cycles < DEPTH + 20) begin
            tick();
            drive(1'b0, 1'b0, '0, '0);
            cycles++;
            if (bus.init_busy)  busy++;
            if (sbus.init_busy) sbusy++;
            if (bus.req_ready) break;
        end
        model_reset();
    endtask

    task automatic test_reset();
        int cyc, busy, sbusy;
        drive(1'b0, 1'b0, '0, '0);
        sdrive(1'b0, 1'b0, '0, '0);
        #1 RST_N = 1'b0;
        #1;
        nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b exp 0", bus.req_ready); end
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp got %b exp 0", bus.rsp_valid); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL rst_data got %h exp 00", bus.data_out); end
        nvec++; if (bus.init_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", bus.init_busy); end
        tick();
        tick();
        release_and_count(cyc, busy, sbusy);
        nvec++; if (cyc !== EXP_CYCLES) begin nerr++; $display("FAIL sweep_len got %0d exp %0d", cyc, EXP_CYCLES); end
        nvec++; if (busy !== EXP_BUSY) begin nerr++; $display("FAIL busy_cycles got %0d exp %0d", busy, EXP_BUSY); end
        nvec++; if (bus.init_busy !== 1'b0) begin nerr++; $display("FAIL ready_busy got %b exp 0", bus.init_busy); end
    endtask

    task automatic test_write_read();
        bit er;
`ifdef DATA_MEM_V2_INIT_CLEAR_EN
        drive(1'b1, 1'b0, 8'd42, '0); tick(); model_step(1'b1, 1'b0, 8'd42, '0, er);
        nvec++; if (bus.rsp_valid !== 1'b1) begin nerr++; $display("FAIL rd42_valid got %b exp 1", bus.rsp_valid); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL rd42_data got %h exp 00", bus.data_out); end
`endif
        drive(1'b1, 1'b1, 8'd0, 8'd33); tick(); model_step(1'b1, 1'b1, 8'd0, 8'd33, er);
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr0_valid got %b exp 0", bus.rsp_valid); end
        drive(1'b1, 1'b0, 8'd0, '0); tick(); model_step(1'b1, 1'b0, 8'd0, '0, er);
        nvec++; if (bus.rsp_valid !== 1'b1) begin nerr++; $display("FAIL rd0_valid got %b exp 1", bus.rsp_valid); end
        nvec++; if (bus.data_out !== 8'd33) begin nerr++; $display("FAIL rd0_data got %h exp %h", bus.data_out, 8'd33); end
        drive(1'b0, 1'b0, '0, '0); tick();
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL idle_valid got %b exp 0", bus.rsp_valid); end
        nvec++; if (bus.data_out !== 8'd33) begin nerr++; $display("FAIL hold_data got %h exp %h", bus.data_out, 8'd33); end
    endtask

    task automatic test_back_to_back();
        bit er;
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'($urandom);
            drive(1'b1, 1'b1, AW'(i), d); tick(); model_step(1'b1, 1'b1, AW'(i), d, er);
            nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL b2b_wr_valid a=%0d got %b exp 0", i, bus.rsp_valid); end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            drive(1'b1, 1'b0, AW'(i), '0); tick(); model_step(1'b1, 1'b0, AW'(i), '0, er);
            nvec++; if (bus.rsp_valid !== 1'b1 || bus.data_out !== exp_dout) begin
                nerr++; $display("FAIL b2b_rd a=%0d got v=%b d=%h exp v=1 d=%h", i, bus.rsp_valid, bus.data_out, exp_dout);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        bit v, w, er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1);
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            d = DW'($urandom);
            drive(v, w, a, d); tick(); model_step(v, w, a, d, er);
            nvec++; if (bus.rsp_valid !== er || bus.data_out !== exp_dout) begin
                nerr++; $display("FAIL rnd n=%0d got v=%b d=%h exp v=%b d=%h", n, bus.rsp_valid, bus.data_out, er, exp_dout);
            end
            nvec++; if (bus.req_ready !== 1'b1 || bus.init_busy !== 1'b0) begin
                nerr++; $display("FAIL rnd_ctl n=%0d got rdy=%b busy=%b exp rdy=1 busy=0", n, bus.req_ready, bus.init_busy);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_not_ready();
        int cyc, busy, sbusy;
        bit er;
        RST_N = 1'b0;
        drive(1'b1, 1'b0, 8'd43, '0);
        tick();
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL nr_rd_valid got %b exp 0", bus.rsp_valid); end
        drive(1'b1, 1'b1, 8'd43, 8'h55);
        tick();
        release_and_count(cyc, busy, sbusy);
        nvec++; if (cyc !== EXP_CYCLES) begin nerr++; $display("FAIL nr_len got %0d exp %0d", cyc, EXP_CYCLES); end
        drive(1'b1, 1'b0, 8'd43, '0); tick(); model_step(1'b1, 1'b0, 8'd43, '0, er);
        nvec++; if (bus.data_out !== exp_dout) begin nerr++; $display("FAIL nr_drop got %h exp %h", bus.data_out, exp_dout); end
        drive(1'b1, 1'b1, 8'd43, 8'h21); tick(); model_step(1'b1, 1'b1, 8'd43, 8'h21, er);
        drive(1'b1, 1'b0, 8'd43, '0); tick(); model_step(1'b1, 1'b0, 8'd43, '0, er);
        nvec++; if (bus.rsp_valid !== 1'b1 || bus.data_out !== 8'h21) begin
            nerr++; $display("FAIL nr_rd43 got v=%b d=%h exp v=1 d=21", bus.rsp_valid, bus.data_out);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_read_reset();
        int cyc, busy, sbusy;
        bit er;
        drive(1'b1, 1'b1, 8'd7, 8'h3C); tick(); model_step(1'b1, 1'b1, 8'd7, 8'h3C, er);
        drive(1'b1, 1'b0, 8'd7, '0); tick(); model_step(1'b1, 1'b0, 8'd7, '0, er);
        nvec++; if (bus.rsp_valid !== 1'b1 || bus.data_out !== 8'h3C) begin
            nerr++; $display("FAIL rr_pre got v=%b d=%h exp v=1 d=3c", bus.rsp_valid, bus.data_out);
        end
        #2 RST_N = 1'b0;
        #1;
        nvec++; if (bus.rsp_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            nerr++; $display("FAIL rr_async got v=%b d=%h exp v=0 d=00", bus.rsp_valid, bus.data_out);
        end
        tick();
        RST_N = 1'b1;
        tick();
        #3 RST_N = 1'b0;
        tick();
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rr_inflight got %b exp 0", bus.rsp_valid); end
        drive(1'b0, 1'b0, '0, '0);
        release_and_count(cyc, busy, sbusy);
        nvec++; if (busy !== EXP_BUSY) begin nerr++; $display("FAIL rr_busy got %0d exp %0d", busy, EXP_BUSY); end
    endtask

    task automatic test_persist();
        int cyc, busy, sbusy;
        bit er;
        drive(1'b1, 1'b1, 8'd5, 8'd7); tick(); model_step(1'b1, 1'b1, 8'd5, 8'd7, er);
        drive(1'b0, 1'b0, '0, '0);
        RST_N = 1'b0;
        tick();
        release_and_count(cyc, busy, sbusy);
        nvec++; if (cyc !== EXP_CYCLES) begin nerr++; $display("FAIL ps_len got %0d exp %0d", cyc, EXP_CYCLES); end
        drive(1'b1, 1'b0, 8'd5, '0); tick(); model_step(1'b1, 1'b0, 8'd5, '0, er);
        nvec++; if (bus.rsp_valid !== 1'b1 || bus.data_out !== exp_dout) begin
            nerr++; $display("FAIL ps_rd5 got v=%b d=%h exp v=1 d=%h", bus.rsp_valid, bus.data_out, exp_dout);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

`ifdef DATA_MEM_V2_INIT_CLEAR_EN
    task automatic test_mid_sweep();
        int cyc, busy, sbusy;
        bit er;
        drive(1'b1, 1'b1, 8'd200, 8'hA5); tick(); model_step(1'b1, 1'b1, 8'd200, 8'hA5, er);
        drive(1'b0, 1'b0, '0, '0);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        repeat (101) tick();
        nvec++; if (bus.init_busy !== 1'b1) begin nerr++; $display("FAIL ms_busy got %b exp 1", bus.init_busy); end
        #2 RST_N = 1'b0;
        #1;
        nvec++; if (bus.init_busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            nerr++; $display("FAIL ms_async got busy=%b rdy=%b v=%b d=%h exp 0 0 0 00",
                             bus.init_busy, bus.req_ready, bus.rsp_valid, bus.data_out);
        end
        tick();
        release_and_count(cyc, busy, sbusy);
        nvec++; if (busy !== DEPTH) begin nerr++; $display("FAIL ms_restart got %0d exp %0d", busy, DEPTH); end
        drive(1'b1, 1'b0, 8'd200, '0); tick(); model_step(1'b1, 1'b0, 8'd200, '0, er);
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL ms_rd200 got %h exp 00", bus.data_out); end
        drive(1'b0, 1'b0, '0, '0);
    endtask
`endif

    task automatic test_small();
        int cyc, busy, sbusy;
        RST_N = 1'b0;
        tick();
        release_and_count(cyc, busy, sbusy);
        nvec++; if (sbusy !== EXP_SBUSY) begin nerr++; $display("FAIL sm_busy got %0d exp %0d", sbusy, EXP_SBUSY); end
        nvec++; if (sbus.req_ready !== 1'b1) begin nerr++; $display("FAIL sm_ready got %b exp 1", sbus.req_ready); end
        sdrive(1'b1, 1'b1, 4'd15, 16'hBEEF); tick();
        nvec++; if (sbus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL sm_wr_valid got %b exp 0", sbus.rsp_valid); end
        sdrive(1'b1, 1'b0, 4'd15, '0); tick();
        nvec++; if (sbus.rsp_valid !== 1'b1 || sbus.data_out !== 16'hBEEF) begin
            nerr++; $display("FAIL sm_rd15 got v=%b d=%h exp v=1 d=beef", sbus.rsp_valid, sbus.data_out);
        end
        sdrive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
        test_not_ready();
        test_read_reset();
        test_persist();
`ifdef DATA_MEM_V2_INIT_CLEAR_EN
        test_mid_sweep();
`endif
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
